// File: rtl/mb_pkg.sv
// Shared definitions for the Math Box microprogram sequencer:
// microword field positions and sequencer state encodings.
package mb_pkg;

  localparam int MW_W      = 16;
  localparam int MW_STOP   = 15;
  localparam int MW_JMP    = 14;
  localparam int MW_JCOND  = 13;
  localparam int MW_M      = 12;
  localparam int MW_A10    = 11;
  localparam int MW_FN_HI  = 10;
  localparam int MW_FN_LO  = 8;
  localparam int MW_TGT_HI = 7;
  localparam int MW_TGT_LO = 0;

  localparam int FN_W  = MW_FN_HI - MW_FN_LO + 1;
  localparam int TGT_W = MW_TGT_HI - MW_TGT_LO + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  // A jump is taken when JMP is set and either it is unconditional or Q0 is high.
  function automatic logic take_jump(input logic [MW_W-1:0] word, input logic q0);
    return word[MW_JMP] && (!word[MW_JCOND] || q0);
  endfunction

endpackage

// File: rtl/mb_sequencer_if.sv
// CPU / microcode ROM / control block #2 signals seen by the Math Box sequencer.
// The slave modport is the sequencer itself; master is whatever surrounds it.
interface mb_sequencer_if #(
  parameter int ADDR_W = 8
);
  import mb_pkg::*;

  logic              START;
  logic [ADDR_W-1:0] START_ADDR;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [MW_W-1:0]   ROM_DATA;
  logic              Q0;
  logic              M;
  logic              A10;
  logic [FN_W-1:0]   ALU_FN;
  logic              ALU_STB;
  logic              BUSY;
  logic              TIMEOUT;

  modport master (
    output START, START_ADDR, ROM_DATA, Q0,
    input  ROM_ADDR, M, A10, ALU_FN, ALU_STB, BUSY, TIMEOUT
  );

  modport slave (
    input  START, START_ADDR, ROM_DATA, Q0,
    output ROM_ADDR, M, A10, ALU_FN, ALU_STB, BUSY, TIMEOUT
  );

endinterface

// File: rtl/mb_sequencer.sv
// Math Box microprogram sequencer: walks the sync microcode ROM two clocks per word
// and hands M / A10 / ALU_FN to control block #2, with a runaway step guard.
module mb_sequencer
  import mb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic          CLK,
  input  logic          RESET,
  mb_sequencer_if.slave bus
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  state_t            state_reg,    state_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic              m_reg,        m_next;
  logic              a10_reg,      a10_next;
  logic [FN_W-1:0]   fn_reg,       fn_next;
  logic              stb_reg,      stb_next;
  logic              busy_reg,     busy_next;
  logic              timeout_reg,  timeout_next;
  logic [STEP_W-1:0] steps_reg,    steps_next;

  logic [TGT_W-1:0]  tgt_field;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] addr_seq;
  logic [STEP_W-1:0] step_inc;

  assign tgt_field = bus.ROM_DATA[MW_TGT_HI:MW_TGT_LO];

  // Jump target fitted to the address width: zero-extend or truncate.
  generate
    if (ADDR_W == TGT_W) begin : g_tgt_same
      assign target = tgt_field;
    end else if (ADDR_W > TGT_W) begin : g_tgt_ext
      assign target = {{(ADDR_W - TGT_W){1'b0}}, tgt_field};
    end else begin : g_tgt_trunc
      assign target = tgt_field[ADDR_W-1:0];
    end
  endgenerate

  assign addr_seq = take_jump(bus.ROM_DATA, bus.Q0) ? target
                                                    : rom_addr_reg + ADDR_W'(1);
  assign step_inc = steps_reg + STEP_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= S_IDLE;
      rom_addr_reg <= '0;
      m_reg        <= 1'b0;
      a10_reg      <= 1'b0;
      fn_reg       <= '0;
      stb_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      steps_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      m_reg        <= m_next;
      a10_reg      <= a10_next;
      fn_reg       <= fn_next;
      stb_reg      <= stb_next;
      busy_reg     <= busy_next;
      timeout_reg  <= timeout_next;
      steps_reg    <= steps_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    m_next        = m_reg;
    a10_next      = a10_reg;
    fn_next       = fn_reg;
    stb_next      = 1'b0;
    busy_next     = busy_reg;
    timeout_next  = timeout_reg;
    steps_next    = steps_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.START) begin
          rom_addr_next = bus.START_ADDR;
          busy_next     = 1'b1;
          timeout_next  = 1'b0;
          steps_next    = '0;
          state_next    = S_FETCH;
        end
      end

      // Strobe is registered so it is high for exactly the EXEC cycle.
      S_FETCH: begin
        stb_next   = 1'b1;
        state_next = S_EXEC;
      end

      S_EXEC: begin
        m_next     = bus.ROM_DATA[MW_M];
        a10_next   = bus.ROM_DATA[MW_A10];
        fn_next    = bus.ROM_DATA[MW_FN_HI:MW_FN_LO];
        steps_next = step_inc;
        if (bus.ROM_DATA[MW_STOP]) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end else if (step_inc == STEP_W'(MAX_STEPS)) begin
          rom_addr_next = addr_seq;
          timeout_next  = 1'b1;
          busy_next     = 1'b0;
          state_next    = S_IDLE;
        end else begin
          rom_addr_next = addr_seq;
          state_next    = S_FETCH;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.ROM_ADDR = rom_addr_reg;
  assign bus.M        = m_reg;
  assign bus.A10      = a10_reg;
  assign bus.ALU_FN   = fn_reg;
  assign bus.ALU_STB  = stb_reg;
  assign bus.BUSY     = busy_reg;
  assign bus.TIMEOUT  = timeout_reg;

endmodule

// File: tb/tb_mb_sequencer.sv
// Self-checking bench for mb_sequencer: directed and random microprograms run
// against a sync ROM model, compared with a plain loop-based program walker.
module tb_mb_sequencer;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [15:0] rom [0:255];

  mb_sequencer_if #(.ADDR_W(8)) bus ();

  mb_sequencer #(.ADDR_W(8), .MAX_STEPS(255)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous microcode ROM: data follows the address one clock later.
  always @(posedge clk) bus.ROM_DATA <= rom[bus.ROM_ADDR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) rom[i] = {5'b00000, 11'($urandom)};
  endtask

  task automatic fill_random();
    int r;
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      w = {5'b00000, 11'($urandom)};
      if (r < 6)       w[15] = 1'b1;
      else if (r < 24) begin
        w[14] = 1'b1;
        w[13] = 1'($urandom);
      end
      rom[i] = w;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"}, 32'(bus.ROM_ADDR), 32'h0);
    check({tag, "_fields"}, 32'({bus.M, bus.A10, bus.ALU_FN}), 32'h0);
    check({tag, "_flags"}, 32'({bus.ALU_STB, bus.BUSY, bus.TIMEOUT}), 32'h0);
  endtask

  // Start a run at sa with Q0 held at q0; optionally re-strobe START (with another
  // address) in the cycle of pulse number poke_at, which must be ignored.
  task automatic run_seq(input string name, input logic [7:0] sa, input logic q0, input int poke_at);
    logic [7:0]  trace[$];
    logic [7:0]  a, nxt, exp_final, fin_addr;
    logic [15:0] w;
    logic        exp_to, prev_stb, done;
    int          steps, cyc, last_stb, n_obs;

    // Reference: walk the program directly from the microword rules.
    a = sa; steps = 0; done = 1'b0; exp_final = 8'h00; exp_to = 1'b0;
    while (!done) begin
      w = rom[a];
      trace.push_back(a);
      steps++;
      nxt = (w[14] && (!w[13] || q0)) ? w[7:0] : a + 8'd1;
      if (w[15]) begin
        exp_final = a; exp_to = 1'b0; done = 1'b1;
      end else if (steps == 255) begin
        exp_final = nxt; exp_to = 1'b1; done = 1'b1;
      end else begin
        a = nxt;
      end
    end

    bus.Q0 = q0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.START_ADDR = sa;
    cyc = 0; last_stb = 0; n_obs = 0; prev_stb = 1'b0;
    while (cyc < 1200) begin
      @(negedge clk);
      cyc++;
      bus.START = 1'b0;
      if (cyc == 1) begin
        check({name, "_busy_on_start"}, 32'(bus.BUSY), 32'h1);
        check({name, "_timeout_cleared"}, 32'(bus.TIMEOUT), 32'h0);
      end
      if (prev_stb && n_obs <= trace.size()) begin
        w = rom[trace[n_obs-1]];
        check({name, "_fields"}, 32'({bus.M, bus.A10, bus.ALU_FN}), 32'({w[12], w[11], w[10:8]}));
      end
      if (bus.ALU_STB) begin
        check({name, "_stb_spacing"}, 32'(cyc - last_stb), 32'd2);
        if (n_obs < trace.size())
          check({name, "_exec_addr"}, 32'(bus.ROM_ADDR), 32'(trace[n_obs]));
        else
          check({name, "_extra_stb"}, 32'h1, 32'h0);
        n_obs++;
        last_stb = cyc;
        if (n_obs - 1 == poke_at) begin
          bus.START = 1'b1;
          bus.START_ADDR = sa ^ 8'h55;
        end
      end
      prev_stb = bus.ALU_STB;
      if (cyc > 1 && !bus.BUSY) break;
    end
    bus.START = 1'b0;
    check({name, "_run_bound"}, 32'(cyc < 1200), 32'h1);
    check({name, "_stb_count"}, 32'(n_obs), 32'(trace.size()));
    check({name, "_timeout"}, 32'(bus.TIMEOUT), 32'(exp_to));
    check({name, "_final_addr"}, 32'(bus.ROM_ADDR), 32'(exp_final));
    fin_addr = bus.ROM_ADDR;
    repeat (3) @(negedge clk);
    check({name, "_stays_idle"}, 32'({bus.BUSY, bus.ALU_STB}), 32'h0);
    check({name, "_addr_holds"}, 32'(bus.ROM_ADDR), 32'(fin_addr));
    $display("run %-14s start=%02h q0=%0d steps=%0d timeout=%0d end_addr=%02h",
             name, sa, q0, n_obs, bus.TIMEOUT, bus.ROM_ADDR);
  endtask

  task automatic reset_mid_exec();
    int cyc;
    int pulses;
    fill_plain();
    rom[8'h6A] = rom[8'h6A] | 16'h8000;
    for (int i = 8'h60; i < 8'h6A; i++) rom[i] = rom[i] | 16'h1F00;
    @(negedge clk);
    bus.START = 1'b1;
    bus.START_ADDR = 8'h60;
    @(negedge clk);
    bus.START = 1'b0;
    pulses = 0;
    for (cyc = 0; cyc < 20 && pulses < 3; cyc++) begin
      if (bus.ALU_STB) pulses++;
      if (pulses < 3) @(negedge clk);
    end
    check("rst_reach_exec", 32'(bus.ALU_STB), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_after");
    $display("run reset_mid_exec  pulses_before_reset=%0d", pulses);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.START_ADDR = 8'h00;
    bus.Q0 = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_release");

    fill_plain();
    rom[8'h13] = rom[8'h13] | 16'h8000;
    run_seq("straight", 8'h10, 1'b0, -1);

    fill_plain();
    rom[8'h20] = 16'h6040 | (rom[8'h20] & 16'h1F00);
    rom[8'h40] = rom[8'h40] | 16'h8000;
    rom[8'h21] = rom[8'h21] | 16'h8000;
    run_seq("jcond_q0_1", 8'h20, 1'b1, -1);
    run_seq("jcond_q0_0", 8'h20, 1'b0, -1);

    fill_plain();
    rom[8'h00] = rom[8'h00] | 16'h8000;
    run_seq("wrap", 8'hFF, 1'b0, -1);

    for (int i = 0; i < 256; i++) rom[i] = 16'h4000 | (16'(i) & 16'h00FF) | 16'(($urandom & 32'h1F) << 8);
    run_seq("runaway", 8'h37, 1'b0, -1);

    fill_plain();
    rom[8'h05] = rom[8'h05] | 16'h8000;
    run_seq("after_timeout", 8'h03, 1'b1, -1);

    fill_plain();
    rom[8'h38] = rom[8'h38] | 16'h8000;
    run_seq("start_busy", 8'h30, 1'b0, 2);
    run_seq("start_at_stop", 8'h30, 1'b0, 8);

    reset_mid_exec();
    fill_plain();
    rom[8'h0B] = rom[8'h0B] | 16'h8000;
    run_seq("post_reset", 8'h08, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      fill_random();
      run_seq($sformatf("random_%0d", n), 8'($urandom), 1'($urandom), int'($urandom_range(0, 4)) - 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
